key_repeat_pad: RTL and testbench

KEY_REPEAT_PAD -- requirements
Module: key_repeat_pad

---
 rtl/pad_pkg.sv | 22 ++
 rtl/key_repeat_chan.sv | 71 +++++++
 rtl/key_repeat_pad.sv | 70 +++++++
 tb/tb_key_repeat_pad.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared encodings for the key repeat pad: move directions, channel FSM states
// and the fixed-priority pick used by the move arbiter.
package pad_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Lowest set bit wins, so "up" beats every other direction.
    function automatic logic [1:0] lowest_dir(input logic [3:0] evt);
        if (evt[0])      return DIR_UP;
        else if (evt[1]) return DIR_DOWN;
        else if (evt[2]) return DIR_LEFT;
        else             return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/key_repeat_chan.sv
// One button channel: press detection, hold delay, auto-repeat and release,
// all emitted as registered single-cycle pulses.
module key_repeat_chan
    import pad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic btn,
    output logic press,
    output logic release_ev,
    output logic repeat_ev,
    output logic held
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only; disable acts
    // like a reset that emits nothing, so a held button re-enters as a press.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            press      <= 1'b0;
            release_ev <= 1'b0;
            repeat_ev  <= 1'b0;
        end else begin
            press      <= 1'b0;
            release_ev <= 1'b0;
            repeat_ev  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        press <= 1'b1;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    // Release is checked first so it beats a same-cycle repeat.
                    if (!btn) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        release_ev <= 1'b1;
                    end else if (cnt == ((state == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                        state     <= ST_REPEAT;
                        cnt       <= '0;
                        repeat_ev <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign held = (state != ST_IDLE);

endmodule

// File: rtl/key_repeat_pad.sv
// Four-button pad: per-button repeat channels feeding a fixed-priority arbiter
// and a single-entry valid/ready move register with a sticky drop flag.
module key_repeat_pad
    import pad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_state,
    input  logic       enable,
    input  logic       move_ready,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] held,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       drop_flag
);

    logic [3:0] repeat_pulse;
    logic [3:0] evt;
    logic       multi_evt;
    logic       slot_free;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        key_repeat_chan #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .btn       (btn_state[i]),
            .press     (press_pulse[i]),
            .release_ev(release_pulse[i]),
            .repeat_ev (repeat_pulse[i]),
            .held      (held[i])
        );
    end

    assign evt       = press_pulse | repeat_pulse;
    assign multi_evt = (evt & (evt - 4'd1)) != 4'd0;
    assign slot_free = !move_valid || move_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            move_valid <= 1'b0;
            move_dir   <= DIR_UP;
            drop_flag  <= 1'b0;
        end else begin
            if (evt != 4'd0) begin
                // An accept in the same cycle frees the slot, so load without a bubble.
                if (slot_free) begin
                    move_valid <= 1'b1;
                    move_dir   <= lowest_dir(evt);
                end
                if (multi_evt || !slot_free) begin
                    drop_flag <= 1'b1;
                end
            end else if (move_valid && move_ready) begin
                move_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_repeat_pad.sv
// Directed bench for key_repeat_pad with short hold/repeat times (8 / 4 cycles).
module tb_key_repeat_pad;
    import pad_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_state;
    logic       enable;
    logic       move_ready;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] held;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       drop_flag;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] tr_pp, tr_rp, tr_held, tr_mv;
    logic [1:0]  dir_or;
    logic [3:0]  any_pulse;
    logic [3:0]  any_held;

    key_repeat_pad #(
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_state    (btn_state),
        .enable       (enable),
        .move_ready   (move_ready),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .held         (held),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .drop_flag    (drop_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Hold one button for hold_len sampled cycles, then trace n cycles total.
    task automatic run_trace(input int ch, input int hold_len, input int n);
        tr_pp = '0; tr_rp = '0; tr_held = '0; tr_mv = '0; dir_or = '0;
        for (int i = 0; i < n; i++) begin
            btn_state = '0;
            if (i < hold_len) btn_state[ch] = 1'b1;
            tick();
            tr_pp[i]   = press_pulse[ch];
            tr_rp[i]   = release_pulse[ch];
            tr_held[i] = held[ch];
            tr_mv[i]   = move_valid;
            if (move_valid) dir_or = dir_or | move_dir;
        end
    endtask

    initial begin
        rst = 1'b1; btn_state = '0; enable = 1'b1; move_ready = 1'b1;
        tick();
        tick();
        check("reset_press",   {28'd0, press_pulse},   32'h0);
        check("reset_release", {28'd0, release_pulse}, 32'h0);
        check("reset_held",    {28'd0, held},          32'h0);
        check("reset_valid",   {31'd0, move_valid},    32'h0);
        check("reset_dir",     {30'd0, move_dir},      32'h0);
        check("reset_drop",    {31'd0, drop_flag},     32'h0);
        rst = 1'b0;
        tick();

        // Tap left for 3 cycles.
        run_trace(2, 3, 12);
        check("tap_press",   tr_pp,   32'h1);
        check("tap_move",    tr_mv,   32'h2);
        check("tap_dir",     {30'd0, dir_or}, 32'h2);
        check("tap_release", tr_rp,   32'h8);
        check("tap_held",    tr_held, 32'h7);

        // Hold up for 20 cycles: press at 0, repeats at 8/12/16, moves one later.
        run_trace(0, 20, 30);
        check("hold_press",   tr_pp,   32'h1);
        check("hold_moves",   tr_mv,   32'h0002_2202);
        check("hold_dir",     {30'd0, dir_or}, 32'h0);
        check("hold_held",    tr_held, 32'h000F_FFFF);
        check("hold_release", tr_rp,   32'h0010_0000);
        check("hold_nodrop",  {31'd0, drop_flag}, 32'h0);

        // Down and right pressed together: down wins, right is dropped.
        btn_state = 4'b1010;
        tick();
        check("dual_press", {28'd0, press_pulse}, 32'ha);
        tick();
        check("dual_valid", {31'd0, move_valid}, 32'h1);
        check("dual_dir",   {30'd0, move_dir},   32'h1);
        check("dual_drop",  {31'd0, drop_flag},  32'h1);
        btn_state = '0;
        for (int i = 0; i < 4; i++) tick();
        do_reset();
        tick();
        check("drop_cleared", {31'd0, drop_flag}, 32'h0);

        // Stalled consumer: up occupies the slot, left arrives and is dropped.
        move_ready = 1'b0;
        btn_state  = 4'b0001;
        tick();
        btn_state = 4'b0100;
        tick();
        check("stall_first_valid", {31'd0, move_valid}, 32'h1);
        check("stall_first_dir",   {30'd0, move_dir},   32'h0);
        check("stall_drop_before", {31'd0, drop_flag},  32'h0);
        btn_state = '0;
        tick();
        check("stall_hold_valid", {31'd0, move_valid}, 32'h1);
        check("stall_hold_dir",   {30'd0, move_dir},   32'h0);
        check("stall_drop",       {31'd0, drop_flag},  32'h1);
        tick();
        check("stall_still_valid", {31'd0, move_valid}, 32'h1);
        move_ready = 1'b1;
        tick();
        check("stall_drained", {31'd0, move_valid}, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        tick();

        // Reset at hold count 5 with the button still high.
        btn_state = 4'b0001;
        tick();
        check("rst_hold_press", {28'd0, press_pulse}, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_no_release", {28'd0, release_pulse}, 32'h0);
        check("rst_held_clear", {28'd0, held},          32'h0);
        check("rst_no_press",   {28'd0, press_pulse},   32'h0);
        tick();
        check("rst_repress",    {28'd0, press_pulse},   32'h1);
        check("rst_repress_rl", {28'd0, release_pulse}, 32'h0);
        check("rst_drop",       {31'd0, drop_flag},     32'h0);
        btn_state = '0;
        for (int i = 0; i < 4; i++) tick();

        // Disable while holding right, then re-enable with the button still high.
        btn_state = 4'b1000;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("en_held_before", {28'd0, held}, 32'h8);
        enable    = 1'b0;
        any_pulse = '0;
        any_held  = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            any_pulse = any_pulse | press_pulse | release_pulse;
            any_held  = any_held | held;
        end
        check("en_off_held",   {28'd0, any_held},  32'h0);
        check("en_off_pulses", {28'd0, any_pulse}, 32'h0);
        check("en_off_valid",  {31'd0, move_valid}, 32'h0);
        enable = 1'b1;
        tick();
        check("en_on_press", {28'd0, press_pulse}, 32'h8);
        check("en_on_held",  {28'd0, held},        32'h8);
        tick();
        check("en_on_move_dir", {30'd0, move_dir}, 32'h3);
        btn_state = '0;
        for (int i = 0; i < 3; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
